// File: rtl/collision_detector.sv
// Frame-based ball/paddle/wall collision and scoring for a pong playfield.
// Ports: clk, reset (sync, active-high); frame_tick, serve; bx, by, bx_dir,
//   by_dir, pl_y, pr_y in; paddle_collision, wall_collision, score_left,
//   score_right pulses and in_play level out.
module collision_detector #(
  parameter int SCREEN_W   = 640,
  parameter int SCREEN_H   = 480,
  parameter int BALL_SIZE  = 8,
  parameter int PADDLE_W   = 8,
  parameter int PADDLE_H   = 64,
  parameter int PADDLE_L_X = 16,
  parameter int PADDLE_R_X = 616,
  parameter int HOLDOFF    = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       frame_tick,
  input  logic       serve,
  input  logic [9:0] bx,
  input  logic [9:0] by,
  input  logic       bx_dir,
  input  logic       by_dir,
  input  logic [9:0] pl_y,
  input  logic [9:0] pr_y,
  output logic       paddle_collision,
  output logic       wall_collision,
  output logic       score_left,
  output logic       score_right,
  output logic       in_play
);

  typedef enum logic [1:0] {
    IDLE,
    EVAL,
    SCORED
  } state_t;

  localparam logic [10:0] K_BS    = 11'(BALL_SIZE);
  localparam logic [10:0] K_PH    = 11'(PADDLE_H);
  localparam logic [10:0] K_LX    = 11'(PADDLE_L_X);
  localparam logic [10:0] K_LX_HI = 11'(PADDLE_L_X + PADDLE_W);
  localparam logic [10:0] K_RX    = 11'(PADDLE_R_X);
  localparam logic [10:0] K_RX_HI = 11'(PADDLE_R_X + PADDLE_W);
  localparam logic [10:0] K_WALL  = 11'(SCREEN_H - BALL_SIZE);
  localparam logic [10:0] K_EDGE  = 11'(SCREEN_W - BALL_SIZE);
  localparam logic [2:0]  K_HOLD  = 3'(HOLDOFF);

  state_t state, state_nx;

  logic [9:0] r_bx, r_by, r_pl, r_pr;
  logic       r_bxd, r_byd;
  logic       sup;
  logic [2:0] cnt;

  logic [10:0] x, y, pl, pr;
  logic        wall_hit, l_hit, r_hit;
  logic        pad, sc_l, sc_r, wall;

  // Zero-extend so sums such as x+BALL_SIZE never wrap.
  assign x  = {1'b0, r_bx};
  assign y  = {1'b0, r_by};
  assign pl = {1'b0, r_pl};
  assign pr = {1'b0, r_pr};

  always_comb begin
    wall_hit = ((y == 11'd0) && !r_byd) ||
               ((y >= K_WALL) && r_byd);
    l_hit = !r_bxd &&
            (x <= K_LX_HI) &&
            (x + K_BS > K_LX) &&
            (y + K_BS > pl) &&
            (y < pl + K_PH);
    r_hit = r_bxd &&
            (x + K_BS >= K_RX) &&
            (x < K_RX_HI) &&
            (y + K_BS > pr) &&
            (y < pr + K_PH);
    pad  = (l_hit || r_hit) && !sup;
    sc_r = (x == 11'd0) && !r_bxd && !pad;
    sc_l = (x >= K_EDGE) && r_bxd && !pad;
    // A score ends the rally, so a wall bounce is meaningless.
    wall = wall_hit && !(sc_l || sc_r);
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (frame_tick) state_nx = EVAL;
      EVAL:    state_nx = (sc_l || sc_r) ? SCORED : IDLE;
      SCORED:  if (serve) state_nx = IDLE;
      default: state_nx = SCORED;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state            <= SCORED;
      r_bx             <= '0;
      r_by             <= '0;
      r_pl             <= '0;
      r_pr             <= '0;
      r_bxd            <= 1'b0;
      r_byd            <= 1'b0;
      sup              <= 1'b0;
      cnt              <= '0;
      paddle_collision <= 1'b0;
      wall_collision   <= 1'b0;
      score_left       <= 1'b0;
      score_right      <= 1'b0;
      in_play          <= 1'b0;
    end else begin
      state            <= state_nx;
      paddle_collision <= 1'b0;
      wall_collision   <= 1'b0;
      score_left       <= 1'b0;
      score_right      <= 1'b0;
      if (state == IDLE && frame_tick) begin
        r_bx  <= bx;
        r_by  <= by;
        r_pl  <= pl_y;
        r_pr  <= pr_y;
        r_bxd <= bx_dir;
        r_byd <= by_dir;
        sup   <= (cnt != 3'd0);
        if (cnt != 3'd0) cnt <= cnt - 3'd1;
      end
      if (state == EVAL) begin
        paddle_collision <= pad;
        wall_collision   <= wall;
        score_left       <= sc_l;
        score_right      <= sc_r;
        if (pad) cnt <= K_HOLD;
        if (sc_l || sc_r) in_play <= 1'b0;
      end
      if (state == SCORED && serve) begin
        cnt     <= '0;
        in_play <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_collision_detector.sv
// Directed plus randomized bench for collision_detector.
// Expected results come from an integer rule model of the playfield.
module tb_collision_detector;

  localparam int SW   = 640;
  localparam int SH   = 480;
  localparam int BS   = 8;
  localparam int PW   = 8;
  localparam int PH   = 64;
  localparam int PLX  = 16;
  localparam int PRX  = 616;
  localparam int HOLD = 4;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       frame_tick = 1'b0;
  logic       serve = 1'b0;
  logic [9:0] bx = '0, by = '0, pl_y = '0, pr_y = '0;
  logic       bx_dir = 1'b0, by_dir = 1'b0;
  logic       paddle_collision, wall_collision;
  logic       score_left, score_right, in_play;

  int checks = 0;
  int errors = 0;

  // Model state: rally flag, accepted-frame index, index of last hit.
  bit m_in_play = 0;
  int m_frames = 0;
  int m_last_hit = -100;
  logic [4:0] obs_p2;

  collision_detector dut (
    .clk              (clk),
    .reset            (reset),
    .frame_tick       (frame_tick),
    .serve            (serve),
    .bx               (bx),
    .by               (by),
    .bx_dir           (bx_dir),
    .by_dir           (by_dir),
    .pl_y             (pl_y),
    .pr_y             (pr_y),
    .paddle_collision (paddle_collision),
    .wall_collision   (wall_collision),
    .score_left       (score_left),
    .score_right      (score_right),
    .in_play          (in_play)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog observed timeout expected finish");
    $fatal(1, "timeout");
  end

  function automatic logic [4:0] outs();
    return {paddle_collision, wall_collision,
            score_left, score_right, in_play};
  endfunction

  task automatic chk(input string tag, input logic [4:0] obs,
                     input logic [4:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %b expected %b", tag, obs, exp);
    end
  endtask

  // One frame: tick raised now, pulses due two edges later.
  task automatic frame(input int x, input int y, input int xd,
                       input int yd, input int l, input int r,
                       input bit dbl);
    bit acc, sup, lh, rh, wh, pc, wc, sl, sr, ip0;
    ip0 = m_in_play;
    acc = m_in_play;
    pc = 0; wc = 0; sl = 0; sr = 0;
    if (acc) begin
      m_frames++;
      sup = (m_frames - m_last_hit) <= HOLD;
      lh = (xd == 0) && (x <= PLX + PW) && (x + BS > PLX) &&
           (y + BS > l) && (y < l + PH);
      rh = (xd == 1) && (x + BS >= PRX) && (x < PRX + PW) &&
           (y + BS > r) && (y < r + PH);
      wh = (y == 0 && yd == 0) || (y >= SH - BS && yd == 1);
      pc = (lh || rh) && !sup;
      sr = !pc && x == 0 && xd == 0;
      sl = !pc && x >= SW - BS && xd == 1;
      wc = wh && !sl && !sr;
      if (pc) m_last_hit = m_frames;
      if (sl || sr) m_in_play = 0;
    end
    bx = 10'(x); by = 10'(y);
    bx_dir = 1'(xd); by_dir = 1'(yd);
    pl_y = 10'(l); pr_y = 10'(r);
    frame_tick = 1'b1;
    @(posedge clk); #1;
    if (!dbl) frame_tick = 1'b0;
    chk("eval_cycle", outs(), {4'b0, ip0});
    @(posedge clk); #1;
    frame_tick = 1'b0;
    obs_p2 = outs();
    chk("pulse", obs_p2, {pc, wc, sl, sr, m_in_play});
    @(posedge clk); #1;
    chk("after", outs(), {4'b0, m_in_play});
  endtask

  task automatic do_serve();
    serve = 1'b1;
    if (!m_in_play) begin
      m_in_play = 1;
      m_last_hit = -100;
    end
    @(posedge clk); #1;
    serve = 1'b0;
    chk("serve", outs(), {4'b0, m_in_play});
  endtask

  function automatic int pick_x();
    unique case ($urandom_range(0, 5))
      0: return 0;
      1: return $urandom_range(SW - BS - 2, SW - 1);
      2: return $urandom_range(PLX - BS - 2, PLX + PW + 2);
      3: return $urandom_range(PRX - BS - 2, PRX + PW + 2);
      4: return $urandom_range(0, 1023);
      default: return $urandom_range(0, SW - 1);
    endcase
  endfunction

  function automatic int pick_y();
    unique case ($urandom_range(0, 3))
      0: return 0;
      1: return $urandom_range(SH - BS - 2, SH - 1);
      2: return $urandom_range(0, 1023);
      default: return $urandom_range(0, SH - 1);
    endcase
  endfunction

  function automatic int pick_p(input int y);
    if ($urandom_range(0, 1) == 1)
      return $urandom_range(0, 1023);
    return (y + 70 > 1023) ? 1023 - $urandom_range(0, 80)
                           : y + 8 - $urandom_range(0, 80) + 72;
  endfunction

  initial begin
    int x, y;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_state", outs(), 5'b00000);
    reset = 1'b0;
    @(posedge clk); #1;
    chk("no_serve_yet", outs(), 5'b00000);
    do_serve();

    frame(20, 100, 0, 0, 80, 0, 0);
    chk("d_hit", obs_p2, 5'b10001);
    for (int i = 0; i < 4; i++) begin
      frame(20, 100, 0, 0, 80, 0, 0);
      chk("d_holdoff", obs_p2, 5'b00001);
    end
    frame(20, 100, 0, 0, 80, 0, 0);
    chk("d_hit6", obs_p2, 5'b10001);

    frame(300, 472, 0, 1, 80, 0, 0);
    chk("d_wall_bot", obs_p2, 5'b01001);
    frame(300, 0, 0, 1, 80, 0, 1);
    chk("d_top_down", obs_p2, 5'b00001);

    frame(0, 100, 0, 0, 300, 0, 0);
    chk("d_score_r", obs_p2, 5'b00010);
    frame(0, 100, 0, 0, 300, 0, 0);
    chk("d_idle_scored", obs_p2, 5'b00000);
    frame(20, 100, 0, 0, 80, 0, 1);
    chk("d_idle_scored2", obs_p2, 5'b00000);
    do_serve();

    frame(20, 0, 0, 0, 0, 0, 0);
    chk("d_corner", obs_p2, 5'b11001);

    frame(640 - 8, 200, 1, 0, 0, 0, 0);
    chk("d_score_l", obs_p2, 5'b00100);
    do_serve();

    // Reset lands while a frame is being evaluated; serve also asserted.
    bx = 10'd20; by = 10'd100; bx_dir = 1'b0; pl_y = 10'd80;
    frame_tick = 1'b1;
    @(posedge clk); #1;
    frame_tick = 1'b0;
    reset = 1'b1;
    serve = 1'b1;
    @(posedge clk); #1;
    chk("rst_abort", outs(), 5'b00000);
    reset = 1'b0;
    serve = 1'b0;
    m_in_play = 0;
    m_last_hit = -100;
    @(posedge clk); #1;
    chk("rst_hold", outs(), 5'b00000);
    do_serve();
    frame(20, 100, 0, 0, 80, 0, 0);
    chk("d_hit_after_rst", obs_p2, 5'b10001);

    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(0, 3) == 0) do_serve();
      x = pick_x();
      y = pick_y();
      frame(x, y, int'($urandom_range(0, 1)),
            int'($urandom_range(0, 1)),
            pick_p(y), pick_p(y), 1'($urandom_range(0, 1)));
    end

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
